// File: rtl/filtro_pkg.sv
// Shared definitions for the filter sequencer and datapath muxes:
// operand select codes, sequencer state encoding and operand count.
package filtro_pkg;

  localparam int unsigned N_OPS = 6;

  localparam logic [3:0] SEL_U    = 4'b0000;
  localparam logic [3:0] SEL_A    = 4'b0001;
  localparam logic [3:0] SEL_B    = 4'b0010;
  localparam logic [3:0] SEL_C    = 4'b0101;
  localparam logic [3:0] SEL_D    = 4'b0110;
  localparam logic [3:0] SEL_E    = 4'b0111;
  localparam logic [3:0] SEL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_LOAD
  } state_t;

  function automatic logic [3:0] sel_code(input logic [2:0] step);
    case (step)
      3'd0:    sel_code = SEL_U;
      3'd1:    sel_code = SEL_A;
      3'd2:    sel_code = SEL_B;
      3'd3:    sel_code = SEL_C;
      3'd4:    sel_code = SEL_D;
      3'd5:    sel_code = SEL_E;
      default: sel_code = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/filtro_seq_dly.sv
// Bit delay line of configurable depth; depth 0 is a plain wire.
module filtro_dly #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
      if (reset) begin
        pipe <= '0;
      end else begin
        pipe[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/filtro_seq.sv
// Operand/accumulator sequencer for the shared-multiplier filter.
// Optional FILTRO_OVERRUN_EN adds the overrun pulse output.
module filtro_seq
  import filtro_pkg::*;
#(
  parameter int unsigned MULT_LAT = 1,
  parameter int unsigned N_OPS    = filtro_pkg::N_OPS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] selec,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       out_load,
  output logic       shift_en,
  output logic       busy,
  output logic       done
`ifdef FILTRO_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam logic [2:0] LAST_STEP  = 3'(N_OPS - 1);
  localparam logic [1:0] LAST_DRAIN = 2'((MULT_LAT == 0) ? 0 : MULT_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] step, step_nxt;
  logic [1:0] drain_cnt, drain_nxt;
  logic       step_valid, step_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      step      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    drain_nxt = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ISSUE;
          step_nxt  = '0;
        end
      end
      ST_ISSUE: begin
        if (step == LAST_STEP) begin
          step_nxt  = '0;
          drain_nxt = '0;
          state_nxt = (MULT_LAT > 0) ? ST_DRAIN : ST_LOAD;
        end else begin
          step_nxt = step + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == LAST_DRAIN) begin
          state_nxt = ST_LOAD;
        end else begin
          drain_nxt = drain_cnt + 2'd1;
        end
      end
      ST_LOAD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    selec = SEL_IDLE;
    if (state == ST_ISSUE) begin
      selec = sel_code(step);
    end
  end

  assign busy     = (state != ST_IDLE);
  assign out_load = (state == ST_LOAD);
  assign shift_en = (state == ST_LOAD);
  assign done     = (state == ST_LOAD);

  // Strobes are aligned to when each product leaves the multiplier pipeline.
  assign step_valid = (state == ST_ISSUE);
  assign step_first = step_valid && (step == '0);

  filtro_dly #(.DEPTH(MULT_LAT)) u_dly_en (
    .clk   (clk),
    .reset (reset),
    .d     (step_valid),
    .q     (acc_en)
  );

  filtro_dly #(.DEPTH(MULT_LAT)) u_dly_clr (
    .clk   (clk),
    .reset (reset),
    .d     (step_first),
    .q     (acc_clr)
  );

`ifdef FILTRO_OVERRUN_EN
  logic overrun_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun      <= 1'b0;
      overrun_seen <= 1'b0;
    end else begin
      overrun <= start && busy;
      if (start && busy) begin
        overrun_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_filtro_seq.sv
// Scoreboard bench for filtro_seq with MULT_LAT = 0, 1 and 3 side by side.
module tb_filtro_seq;
  import filtro_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;

  always #5 clk = ~clk;

  logic [3:0] selec    [3];
  logic       acc_clr  [3];
  logic       acc_en   [3];
  logic       out_load [3];
  logic       shift_en [3];
  logic       busy     [3];
  logic       done     [3];
`ifdef FILTRO_OVERRUN_EN
  logic       overrun  [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    filtro_seq #(.MULT_LAT((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .selec    (selec[g]),
      .acc_clr  (acc_clr[g]),
      .acc_en   (acc_en[g]),
      .out_load (out_load[g]),
      .shift_en (shift_en[g]),
      .busy     (busy[g]),
      .done     (done[g])
`ifdef FILTRO_OVERRUN_EN
      ,
      .overrun  (overrun[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ph     [3];
  logic ovx  [3];
  int n_done [3];
  int n_acc  [3];
  int sb     [$];
  logic [3:0] codes [6] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7};

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d got %0h expected %0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      n_done[i] = 0;
      n_acc[i]  = 0;
    end
  endtask

  // Timeline model: ph is the position within a sample (1 = first issue cycle).
  task automatic tick();
    int old, l, p, idx;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      l      = lat_of(i);
      old    = ph[i];
      ovx[i] = !reset && start && (old != 0);
      if (reset) begin
        ph[i] = 0;
      end else if (old == 0) begin
        if (start) begin
          ph[i] = 1;
          sb.push_back(i * 1000000 + cyc + 6 + l);
        end
      end else begin
        ph[i] = (old == 7 + l) ? 0 : old + 1;
      end
    end
    if (reset) sb.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      l = lat_of(i);
      p = ph[i];
      chk("selec",    i, 32'(selec[i]), 32'((p >= 1 && p <= 6) ? codes[(p >= 1) ? p - 1 : 0] : SEL_IDLE));
      chk("acc_en",   i, 32'(acc_en[i]),   32'(p >= l + 1 && p <= l + 6));
      chk("acc_clr",  i, 32'(acc_clr[i]),  32'(p == l + 1));
      chk("out_load", i, 32'(out_load[i]), 32'(p == l + 7));
      chk("shift_en", i, 32'(shift_en[i]), 32'(p == l + 7));
      chk("done",     i, 32'(done[i]),     32'(p == l + 7));
      chk("busy",     i, 32'(busy[i]),     32'(p != 0));
`ifdef FILTRO_OVERRUN_EN
      chk("overrun",  i, 32'(overrun[i]),  32'(ovx[i]));
`endif
      if (acc_en[i] === 1'b1) n_acc[i]++;
      if (done[i] === 1'b1) begin
        n_done[i]++;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (idx < 0 && sb[k] / 1000000 == i) idx = k;
        end
        if (idx < 0) begin
          chk("done_unexpected", i, 32'(done[i]), 32'b0);
        end else begin
          chk("done_time", i, 32'(cyc), 32'(sb[idx] % 1000000));
          sb.delete(idx);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ph[i]  = 0;
      ovx[i] = 1'b0;
    end
    clear_counts();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single sample in each latency configuration.
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    for (int i = 0; i < 3; i++) begin
      chk("single_acc_count",  i, 32'(n_acc[i]),  32'd6);
      chk("single_done_count", i, 32'(n_done[i]), 32'd1);
    end

    // Second start four cycles in is ignored.
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    for (int i = 0; i < 3; i++) begin
      chk("ignored_done_count", i, 32'(n_done[i]), 32'd1);
    end

    // Reset mid-sequence aborts the sample.
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_selec", 1, 32'(selec[1]), 32'(SEL_IDLE));
    repeat (14) tick();
    for (int i = 0; i < 3; i++) begin
      chk("abort_done_count", i, 32'(n_done[i]), 32'd0);
    end

    // Starts at the minimum spacing for MULT_LAT = 1.
    clear_counts();
    repeat (20) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
    end
    repeat (15) tick();
    chk("b2b_done_count", 1, 32'(n_done[1]), 32'd20);
    chk("b2b_acc_count",  1, 32'(n_acc[1]),  32'd120);
    chk("b2b_done_count", 0, 32'(n_done[0]), 32'd20);

    // Start held high: one sequence per 8+MULT_LAT cycles.
    clear_counts();
    start = 1'b1;
    repeat (36) tick();
    start = 1'b0;
    repeat (15) tick();
    chk("held_done_count", 0, 32'(n_done[0]), 32'd5);
    chk("held_done_count", 1, 32'(n_done[1]), 32'd4);
    chk("held_done_count", 2, 32'(n_done[2]), 32'd4);

    chk("scoreboard_empty", 0, 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filtro_seq.md
# filtro_seq

Sequencer for the shared-multiplier filter datapath. On each sample strobe it walks the filter input mux through the six operand selections (u, a, b, c, d, e) and drives the accumulator clear/enable strobes. It compensates a configurable multiplier pipeline delay, then issues one output-register load and one delay-line shift. It sits between the sample-rate tick generator and the filter datapath (input mux, coefficient mux, multiplier, accumulator, delay registers).

## Interface
- `MULT_LAT`, default 1: pipeline stages between the mux output and the accumulator input; legal values 0..3.
- `N_OPS`, default 6: operand steps per sample; fixed at 6, and other values are unsupported.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  sample strobe, one-cycle pulse.
- `selec`  out  4  operand select to the input and coefficient muxes.
- `acc_clr`  out  1  accumulator loads the product instead of adding it.
- `acc_en`  out  1  accumulator update enable.
- `out_load`  out  1  output register captures the accumulator.
- `shift_en`  out  1  delay-line registers advance one sample.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse, coincident with `out_load`.
- `overrun`  out  1  one-cycle pulse when `start` arrives while busy; present only under the macro.

## Operation
- **Select code order** for steps 0..5: 4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111.
- **Idle select:** `selec` = 4'b1111 whenever not in ISSUE. 4'b1111 is the mux default code and yields a zero operand.
- **IDLE:** all strobes are low. `start`=1 moves to ISSUE with step=0.
- **ISSUE:** `selec` = code[step] and step increments each cycle. After step 5 the FSM goes to DRAIN if `MULT_LAT`>0, otherwise to LOAD.
- **DRAIN:** holds for `MULT_LAT` cycles, then goes to LOAD.
- **LOAD:** `out_load`=`shift_en`=`done`=1 for exactly one cycle, then IDLE.
- **Accumulator strobes:**
  - `acc_en` is the "step valid" flag delayed by `MULT_LAT` cycles through a shift register.
  - `acc_clr` is the "step==0" flag delayed the same way.
  - Each is high for exactly 6 cycles and 1 cycle per sample, respectively.
- **`start` handling:**
  - `start` while busy (ISSUE, DRAIN or LOAD) is ignored; it is never queued.
  - `start` asserted in the same cycle the FSM returns to IDLE is also ignored, because it is sampled in LOAD.
- **Reset:**
  - Applies mid-sequence immediately at the next edge.
  - Returns the FSM to IDLE, step to 0 and the delay pipes to 0.
  - No `out_load` or `shift_en` is issued for the aborted sample.
- **Reset values:** `selec`=4'b1111; all other outputs 0.

## Timing
- `start` sampled high at edge T gives `selec`=code[k] during cycle T+1+k, for k=0..5.
- `acc_en` high during cycles T+1+`MULT_LAT` .. T+6+`MULT_LAT`.
- `acc_clr` high during cycle T+1+`MULT_LAT`.
- `out_load`/`shift_en`/`done` high during cycle T+7+`MULT_LAT`.
- `busy` high from T+1 through T+7+`MULT_LAT` inclusive.
- Minimum `start` spacing is 8+`MULT_LAT` cycles.
- All outputs are registered or decoded from registered state only, with no combinational path from `start`.

## Configuration
- **`FILTRO_OVERRUN_EN`** defined:
  - The `overrun` port exists.
  - It pulses one cycle after any `start` sampled while `busy`=1.
  - A sticky internal flag holds that indication until `reset`.
- **`FILTRO_OVERRUN_EN`** undefined:
  - The `overrun` port and its logic are absent.
  - Ignored starts leave no trace.

## Structure
- **Shared package `filtro_pkg`:**
  - The six select-code constants and `SEL_IDLE`=4'b1111.
  - The FSM state encoding (IDLE, ISSUE, DRAIN, LOAD).
  - `N_OPS`=6.
  - The mux and the sequencer both import these codes.
- **Sub-module `filtro_dly`:** a parameterised-depth bit delay line, with depth 0 as a pass-through. It is instantiated twice, for `acc_en` and `acc_clr`.

## Test plan
1. Reset, then `start` at T with `MULT_LAT`=1 -> `selec` sequence 0,1,2,5,6,7 at T+1..T+6. `acc_clr` at T+2. `acc_en` at T+2..T+7. `out_load`/`done` at T+8. `busy` at T+1..T+8.
2. `MULT_LAT`=0 and `MULT_LAT`=3 -> `out_load` at T+7 and T+10 respectively. The `acc_en` count is 6 in both cases.
3. Second `start` at T+4 -> ignored, with exactly one `out_load`. With `FILTRO_OVERRUN_EN` defined, `overrun` pulses at T+5.
4. `reset` asserted at T+3 -> IDLE at T+4, `selec`=4'b1111, and no `out_load`/`shift_en` for that sample.
5. Back-to-back `start` every 9 cycles (`MULT_LAT`=1) for 20 samples -> 20 `done` pulses, 120 `acc_en` cycles and no overrun.
6. `start` held high continuously -> one sequence per 9 cycles (`MULT_LAT`=1). Starts are re-accepted only from IDLE.
